// File: rtl/fixed_mac_pkg.sv
// Shared types and constants for the fixed-point block MAC.
// Build option: define FIXED_MAC_SAT_EN to saturate the 24-bit result instead of wrapping.
package fixed_mac_pkg;

   localparam int unsigned COEF_W  = 12;
   localparam int unsigned OUT_W   = 24;
   localparam int          SAT_MAX = 8388607;
   localparam int          SAT_MIN = -8388608;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACC,
      ST_HOLD
   } state_t;

   // Accumulator width: signed product (data + zero-extended coef) plus block growth bits.
   function automatic int unsigned acc_width(input int unsigned data_w, input int unsigned acc_len);
      return data_w + COEF_W + 1 + $clog2(acc_len);
   endfunction

endpackage

// File: rtl/fixed_mac_sat.sv
// Reduces the wide accumulator to the 24-bit signed result.
// FIXED_MAC_SAT_EN defined: clamp to the 24-bit signed range; undefined: keep the low 24 bits.
module fixed_mac_sat
   import fixed_mac_pkg::*;
#(
   parameter int unsigned ACC_W = 32
) (
   input  logic signed [ACC_W-1:0] acc,
   output logic signed [OUT_W-1:0] result_c
);

`ifdef FIXED_MAC_SAT_EN
   // Clamp out-of-range sums to the nearest representable 24-bit value.
   always_comb begin
      if (acc > ACC_W'(SAT_MAX)) begin
         result_c = OUT_W'(SAT_MAX);
      end else if (acc < ACC_W'(SAT_MIN)) begin
         result_c = OUT_W'(SAT_MIN);
      end else begin
         result_c = acc[OUT_W-1:0];
      end
   end
`else
   // Two's-complement wrap: the upper accumulator bits are simply dropped.
   logic unused_hi;
   assign unused_hi = ^acc[ACC_W-1:OUT_W];
   assign result_c  = acc[OUT_W-1:0];
`endif

endmodule

// File: rtl/fixed_mac.sv
// Block multiply-accumulate: sums ACC_LEN samples times a per-block coefficient,
// then holds the 24-bit result until downstream takes it.
// Build option: FIXED_MAC_SAT_EN selects saturation of the result (see fixed_mac_sat).
module fixed_mac
   import fixed_mac_pkg::*;
#(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned ACC_LEN = 8
) (
   input  logic                     FIXED_MAC_clk,
   input  logic                     FIXED_MAC_reset,
   input  logic                     FIXED_MAC_init,
   input  logic                     FIXED_MAC_in_disable,
   input  logic [COEF_W-1:0]        FIXED_MAC_in_coef_12,
   input  logic signed [DATA_W-1:0] FIXED_MAC_in_data,
   input  logic                     FIXED_MAC_in_valid,
   output logic                     FIXED_MAC_out_in_ready,
   output logic signed [OUT_W-1:0]  FIXED_MAC_out_result_24,
   output logic                     FIXED_MAC_out_valid,
   input  logic                     FIXED_MAC_in_out_ready
);

   localparam int unsigned PROD_W = DATA_W + COEF_W + 1;
   localparam int unsigned ACC_W  = acc_width(DATA_W, ACC_LEN);
   localparam int unsigned CNT_W  = $clog2(ACC_LEN) + 1;

   state_t                  state_q, state_d;
   logic [COEF_W-1:0]       coef_q, coef_d, mul_coef;
   logic signed [ACC_W-1:0] acc_q, acc_d, acc_base, acc_sum;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic signed [OUT_W-1:0] res_q, res_d, sat_c;
   logic                    vld_q, vld_d;
   logic signed [PROD_W-1:0] prod;
   logic                    reset_i;
   logic                    accept;

   assign reset_i = FIXED_MAC_reset | FIXED_MAC_init;

   // Ready is withdrawn while a result is pending or the block is frozen.
   assign FIXED_MAC_out_in_ready = (state_q != ST_HOLD) && !FIXED_MAC_in_disable;
   assign accept                 = FIXED_MAC_in_valid & FIXED_MAC_out_in_ready;

   // First sample of a block uses the live coefficient and a zero base; later ones use the latched coef.
   always_comb begin
      mul_coef = (state_q == ST_IDLE) ? FIXED_MAC_in_coef_12 : coef_q;
      acc_base = (state_q == ST_IDLE) ? '0 : acc_q;
      prod     = PROD_W'(FIXED_MAC_in_data) * PROD_W'($signed({1'b0, mul_coef}));
      acc_sum  = acc_base + ACC_W'(prod);
   end

   fixed_mac_sat #(
      .ACC_W (ACC_W)
   ) u_sat (
      .acc      (acc_sum),
      .result_c (sat_c)
   );

   // Next-state and next-register values.
   always_comb begin
      state_d = state_q;
      coef_d  = coef_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      vld_d   = vld_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               coef_d  = FIXED_MAC_in_coef_12;
               acc_d   = acc_sum;
               cnt_d   = CNT_W'(1);
               state_d = ST_ACC;
            end
         end
         ST_ACC: begin
            if (accept) begin
               acc_d = acc_sum;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(ACC_LEN - 1)) begin
                  state_d = ST_HOLD;
                  vld_d   = 1'b1;
                  res_d   = sat_c;
               end
            end
         end
         ST_HOLD: begin
            if (!FIXED_MAC_in_disable && FIXED_MAC_in_out_ready) begin
               state_d = ST_IDLE;
               vld_d   = 1'b0;
               acc_d   = '0;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset/init dominate everything.
   always_ff @(posedge FIXED_MAC_clk) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         coef_q  <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         coef_q  <= coef_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         vld_q   <= vld_d;
      end
   end

   assign FIXED_MAC_out_result_24 = res_q;
   assign FIXED_MAC_out_valid     = vld_q;

endmodule
